nvram_ioctl_bridge: RTL and testbench



---
 rtl/nvram_ioctl_bridge.sv | 133 +++++++++++++
 tb/tb_nvram_ioctl_bridge.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nvram_ioctl_bridge.sv
// Bridges the HPS ioctl channel to the 4-bit CMOS NVRAM: each byte is two nibbles (low at even address).
// Optional feature macro: NVRAM_DIRTY_EN (nv_dirty tracks CPU writes since the last save/restore).
module nvram_ioctl_bridge #(
    parameter int unsigned ADDR_W = 10,
    parameter logic [15:0] INDEX  = 16'd4
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic              ioctl_upload,
    input  logic [15:0]       ioctl_index,
    input  logic              ioctl_wr,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic              nv_sel,
    output logic [ADDR_W-1:0] nv_addr,
    output logic              nv_we,
    output logic [3:0]        nv_d,
    input  logic [3:0]        nv_q,
    input  logic              cpu_nv_we,
    output logic              nv_dirty
);

    typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, RD3, WR0, WR1} state_t;

    state_t            state;
    logic              match;
    logic              in_range;
    logic [ADDR_W-2:0] byte_a;
    logic              oor;
    logic [3:0]        nib_hold;

    assign match    = (ioctl_index == INDEX);
    assign in_range = (ioctl_addr[24:ADDR_W-1] == '0);

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state      <= IDLE;
            byte_a     <= '0;
            oor        <= 1'b0;
            nib_hold   <= '0;
            ioctl_din  <= '0;
            ioctl_wait <= 1'b0;
            nv_sel     <= 1'b0;
            nv_addr    <= '0;
            nv_we      <= 1'b0;
            nv_d       <= '0;
        end else begin
            nv_sel <= (ioctl_upload | ioctl_download) & match;
            case (state)
                IDLE: begin
                    if (ioctl_rd && ioctl_upload && match) begin
                        byte_a     <= ioctl_addr[ADDR_W-2:0];
                        oor        <= !in_range;
                        nv_addr    <= {ioctl_addr[ADDR_W-2:0], 1'b0};
                        ioctl_wait <= 1'b1;
                        state      <= RD0;
                    end else if (ioctl_wr && ioctl_download && match && in_range) begin
                        byte_a     <= ioctl_addr[ADDR_W-2:0];
                        nv_addr    <= {ioctl_addr[ADDR_W-2:0], 1'b0};
                        nv_d       <= ioctl_dout[3:0];
                        nib_hold   <= ioctl_dout[7:4];
                        nv_we      <= 1'b1;
                        ioctl_wait <= 1'b1;
                        state      <= WR0;
                    end
                end
                RD0: begin
                    nv_addr <= {byte_a, 1'b1};
                    state   <= RD1;
                end
                RD1: begin
                    // nv_q now carries the low nibble addressed two edges ago
                    nib_hold <= nv_q;
                    state    <= RD2;
                end
                RD2: begin
                    ioctl_din  <= oor ? 8'hFF : {nv_q, nib_hold};
                    ioctl_wait <= 1'b0;
                    state      <= RD3;
                end
                RD3: begin
                    state <= IDLE;
                end
                WR0: begin
                    nv_addr <= {byte_a, 1'b1};
                    nv_d    <= nib_hold;
                    state   <= WR1;
                end
                WR1: begin
                    nv_we      <= 1'b0;
                    ioctl_wait <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef NVRAM_DIRTY_EN
    logic dl_prev;
    logic dirty_set;
    logic dirty_clr;

    assign dirty_set = cpu_nv_we && !nv_sel;
    // A full save ends with the last byte; a restore ends when the matched download drops.
    assign dirty_clr = ((state == RD2) && !oor && (byte_a == '1)) || (dl_prev && !ioctl_download);

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            dl_prev  <= 1'b0;
            nv_dirty <= 1'b0;
        end else begin
            dl_prev <= ioctl_download && match;
            if (dirty_set) begin
                nv_dirty <= 1'b1;
            end else if (dirty_clr) begin
                nv_dirty <= 1'b0;
            end
        end
    end
`else
    logic unused_cpu_nv_we;
    assign unused_cpu_nv_we = cpu_nv_we;
    assign nv_dirty = 1'b0;
`endif

endmodule

// File: tb/tb_nvram_ioctl_bridge.sv
// Bench for nvram_ioctl_bridge: transaction-level model with per-cycle compare, directed plus random ioctl traffic.
// Honours NVRAM_DIRTY_EN the same way the design does.
module tb_nvram_ioctl_bridge;

    localparam int ADDR_W = 10;
    localparam int NBYTES = 1 << (ADDR_W - 1);
    localparam int MAXC   = 16384;

    logic              clk_sys = 1'b0;
    logic              reset_n;
    logic              ioctl_download;
    logic              ioctl_upload;
    logic [15:0]       ioctl_index;
    logic              ioctl_wr;
    logic              ioctl_rd;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic [7:0]        ioctl_din;
    logic              ioctl_wait;
    logic              nv_sel;
    logic [ADDR_W-1:0] nv_addr;
    logic              nv_we;
    logic [3:0]        nv_d;
    logic [3:0]        nv_q = '0;
    logic              cpu_nv_we;
    logic              nv_dirty;

    nvram_ioctl_bridge #(.ADDR_W(ADDR_W), .INDEX(16'd4)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_rd(ioctl_rd),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_din(ioctl_din),
        .ioctl_wait(ioctl_wait), .nv_sel(nv_sel), .nv_addr(nv_addr), .nv_we(nv_we),
        .nv_d(nv_d), .nv_q(nv_q), .cpu_nv_we(cpu_nv_we), .nv_dirty(nv_dirty)
    );

    always #5 clk_sys = ~clk_sys;

    // Registered NVRAM with one cycle of read latency
    logic [3:0] ram [1 << ADDR_W];
    always @(posedge clk_sys) begin
        nv_q <= ram[nv_addr];
        if (nv_we) ram[nv_addr] = nv_d;
    end

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: per-cycle expectation tables filled when a transaction is accepted
    logic [3:0]        ref_nib [1 << ADDR_W];
    bit                exp_wait [MAXC];
    bit                exp_we   [MAXC];
    bit [ADDR_W-1:0]   exp_addr [MAXC];
    bit [3:0]          exp_d    [MAXC];
    int                busy_until = -10;
    int                din_pend = -1;
    logic [7:0]        din_pend_val = '0;
    int                clr_cyc = -1;
    logic [7:0]        din_now = '0;
    logic              sel_now = 1'b0;
    logic              dirty_now = 1'b0;
    logic              dn_prev = 1'b0;

    always @(posedge clk_sys) begin
        int c, n, a;
        logic m, in_r, set_d, clr_d;
        c = cyc;
        n = cyc + 1;
        if (exp_we[c]) ref_nib[exp_addr[c]] = exp_d[c];
        if (!reset_n) begin
            for (int k = n; k < n + 5; k++) begin
                exp_wait[k] = 1'b0;
                exp_we[k]   = 1'b0;
            end
            busy_until = c;
            din_pend   = -1;
            clr_cyc    = -1;
            din_now    = '0;
            sel_now    = 1'b0;
            dirty_now  = 1'b0;
            dn_prev    = 1'b0;
        end else begin
            m     = (ioctl_index == 16'd4);
            in_r  = (ioctl_addr < NBYTES);
            a     = int'(ioctl_addr % NBYTES);
            set_d = cpu_nv_we && !sel_now;
            clr_d = (clr_cyc == n) || (dn_prev && !ioctl_download);
            dn_prev = ioctl_download && m;
            if (din_pend == n) din_now = din_pend_val;
            if (c > busy_until) begin
                if (ioctl_rd && ioctl_upload && m) begin
                    for (int k = n; k < n + 3; k++) exp_wait[k] = 1'b1;
                    busy_until   = c + 4;
                    din_pend     = n + 3;
                    din_pend_val = in_r ? {ref_nib[2*a+1], ref_nib[2*a]} : 8'hFF;
                    if (in_r && a == NBYTES - 1) clr_cyc = n + 3;
                end else if (ioctl_wr && ioctl_download && m && in_r) begin
                    exp_wait[n]   = 1'b1;
                    exp_wait[n+1] = 1'b1;
                    exp_we[n]     = 1'b1;
                    exp_we[n+1]   = 1'b1;
                    exp_addr[n]   = ADDR_W'(2*a);
                    exp_addr[n+1] = ADDR_W'(2*a + 1);
                    exp_d[n]      = ioctl_dout[3:0];
                    exp_d[n+1]    = ioctl_dout[7:4];
                    busy_until    = c + 2;
                end
            end
            sel_now = (ioctl_upload || ioctl_download) && m;
`ifdef NVRAM_DIRTY_EN
            if (set_d) dirty_now = 1'b1;
            else if (clr_d) dirty_now = 1'b0;
`else
            dirty_now = 1'b0;
`endif
        end
        cyc++;
    end

    always @(negedge clk_sys) begin
        if (cyc < MAXC) begin
            chk("wait", {31'd0, ioctl_wait}, {31'd0, exp_wait[cyc]});
            chk("we", {31'd0, nv_we}, {31'd0, exp_we[cyc]});
            if (exp_we[cyc]) begin
                chk("wr_addr", 32'(nv_addr), 32'(exp_addr[cyc]));
                chk("wr_data", 32'(nv_d), 32'(exp_d[cyc]));
            end
            chk("din", 32'(ioctl_din), 32'(din_now));
            chk("sel", {31'd0, nv_sel}, {31'd0, sel_now});
            chk("dirty", {31'd0, nv_dirty}, {31'd0, dirty_now});
        end
    end

    task automatic tick();
        @(negedge clk_sys);
    endtask

    task automatic do_upload(input logic [24:0] a);
        ioctl_upload = 1'b1;
        ioctl_addr   = a;
        ioctl_rd     = 1'b1;
        tick();
        ioctl_rd = 1'b0;
        repeat (4) tick();
    endtask

    task automatic preload(input int addr, input logic [3:0] v);
        ram[addr]     = v;
        ref_nib[addr] = v;
    endtask

    initial begin
        reset_n = 1'b0; ioctl_download = 1'b0; ioctl_upload = 1'b0; ioctl_index = 16'd4;
        ioctl_wr = 1'b0; ioctl_rd = 1'b0; ioctl_addr = '0; ioctl_dout = '0; cpu_nv_we = 1'b0;
        for (int i = 0; i < (1 << ADDR_W); i++) preload(i, 4'($urandom));
        repeat (3) tick();
        chk("rst_din", 32'(ioctl_din), 32'h0);
        chk("rst_addr", 32'(nv_addr), 32'h0);
        chk("rst_nv_d", 32'(nv_d), 32'h0);
        chk("rst_wait", {31'd0, ioctl_wait}, 32'h0);
        chk("rst_dirty", {31'd0, nv_dirty}, 32'h0);
        reset_n = 1'b1;
        tick();

        // Upload byte 0x63 built from nibbles 0x4 / 0xB
        preload(10'h0C6, 4'h4);
        preload(10'h0C7, 4'hB);
        ioctl_upload = 1'b1; tick();
        ioctl_addr = 25'h63; ioctl_rd = 1'b1; tick();
        ioctl_rd = 1'b0;
        chk("up_wait_c1", {31'd0, ioctl_wait}, 32'h1);
        tick(); tick();
        chk("up_wait_c3", {31'd0, ioctl_wait}, 32'h1);
        tick();
        chk("up_wait_c4", {31'd0, ioctl_wait}, 32'h0);
        chk("up_din_b4", 32'(ioctl_din), 32'hB4);
        tick();

        // Download 0x5A to byte 0x10
        ioctl_upload = 1'b0; ioctl_download = 1'b1; tick();
        ioctl_addr = 25'h10; ioctl_dout = 8'h5A; ioctl_wr = 1'b1; tick();
        ioctl_wr = 1'b0;
        chk("dn_we_c1", {31'd0, nv_we}, 32'h1);
        chk("dn_addr_c1", 32'(nv_addr), 32'h020);
        chk("dn_d_c1", 32'(nv_d), 32'hA);
        tick();
        chk("dn_addr_c2", 32'(nv_addr), 32'h021);
        chk("dn_d_c2", 32'(nv_d), 32'h5);
        tick();
        chk("dn_wait_c3", {31'd0, ioctl_wait}, 32'h0);
        chk("dn_we_c3", {31'd0, nv_we}, 32'h0);
        ioctl_download = 1'b0; tick();
        do_upload(25'h10);
        chk("readback_5a", 32'(ioctl_din), 32'h5A);

        // Index and range filtering
        ioctl_index = 16'd0; ioctl_rd = 1'b1; tick();
        ioctl_rd = 1'b0;
        chk("idx0_wait", {31'd0, ioctl_wait}, 32'h0);
        chk("idx0_sel", {31'd0, nv_sel}, 32'h0);
        tick();
        ioctl_index = 16'd4;
        do_upload(25'h200);
        chk("oor_din_ff", 32'(ioctl_din), 32'hFF);
        ioctl_upload = 1'b0; ioctl_download = 1'b1;
        ioctl_addr = 25'h200; ioctl_dout = 8'h33; ioctl_wr = 1'b1; tick();
        ioctl_wr = 1'b0;
        chk("oor_no_we", {31'd0, nv_we}, 32'h0);
        chk("oor_no_wait", {31'd0, ioctl_wait}, 32'h0);
        tick();

        // Reset while in WR0, then a fresh download
        ioctl_addr = 25'h20; ioctl_dout = 8'hC3; ioctl_wr = 1'b1; tick();
        ioctl_wr = 1'b0; reset_n = 1'b0; tick();
        chk("rstwr_we", {31'd0, nv_we}, 32'h0);
        chk("rstwr_wait", {31'd0, ioctl_wait}, 32'h0);
        reset_n = 1'b1; tick();
        ioctl_addr = 25'h21; ioctl_dout = 8'h7E; ioctl_wr = 1'b1; tick();
        ioctl_wr = 1'b0;
        chk("fresh_we", {31'd0, nv_we}, 32'h1);
        chk("fresh_addr", 32'(nv_addr), 32'h042);
        tick(); tick();
        ioctl_download = 1'b0; tick();

        // Second rd during RD1 is ignored
        ioctl_upload = 1'b1; ioctl_addr = 25'h10; ioctl_rd = 1'b1; tick();
        ioctl_rd = 1'b0; tick();
        ioctl_addr = 25'h63; ioctl_rd = 1'b1; tick();
        ioctl_rd = 1'b0; tick();
        chk("b2b_din", 32'(ioctl_din), 32'h5A);
        repeat (3) tick();
        chk("b2b_hold", 32'(ioctl_din), 32'h5A);
        chk("b2b_wait", {31'd0, ioctl_wait}, 32'h0);
        ioctl_upload = 1'b0; tick(); tick();

`ifdef NVRAM_DIRTY_EN
        cpu_nv_we = 1'b1; tick();
        cpu_nv_we = 1'b0;
        chk("dirty_set", {31'd0, nv_dirty}, 32'h1);
        for (int a = 0; a < NBYTES; a++) do_upload(25'(a));
        chk("dirty_clr_full", {31'd0, nv_dirty}, 32'h0);
        ioctl_upload = 1'b0; tick(); tick();
        cpu_nv_we = 1'b1; tick();
        cpu_nv_we = 1'b0; tick();
        ioctl_upload = 1'b1; ioctl_addr = 25'(NBYTES - 1); ioctl_rd = 1'b1; tick();
        ioctl_upload = 1'b0; ioctl_rd = 1'b0; tick(); tick();
        cpu_nv_we = 1'b1; tick();
        cpu_nv_we = 1'b0;
        chk("dirty_set_wins", {31'd0, nv_dirty}, 32'h1);
        tick();
`else
        cpu_nv_we = 1'b1; tick();
        cpu_nv_we = 1'b0;
        chk("dirty_tied", {31'd0, nv_dirty}, 32'h0);
`endif

        // Randomised traffic, including strobes during busy states and rare resets
        begin
            int mode;
            mode = 0;
            for (int i = 0; i < 2500; i++) begin
                reset_n = ($urandom_range(0, 199) != 0);
                if ($urandom_range(0, 9) == 0) mode = $urandom_range(0, 2);
                ioctl_upload   = (mode == 1);
                ioctl_download = (mode == 2);
                ioctl_index    = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'd4;
                ioctl_rd       = ($urandom_range(0, 3) == 0);
                ioctl_wr       = ($urandom_range(0, 3) == 0);
                ioctl_addr     = ($urandom_range(0, 15) == 0) ? 25'($urandom) : 25'($urandom_range(0, NBYTES - 1));
                ioctl_dout     = 8'($urandom);
                cpu_nv_we      = ($urandom_range(0, 7) == 0);
                tick();
            end
        end
        reset_n = 1'b1; ioctl_rd = 1'b0; ioctl_wr = 1'b0; cpu_nv_we = 1'b0;
        ioctl_upload = 1'b0; ioctl_download = 1'b0;
        repeat (6) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
